// File: rtl/accel_driver_pkg.sv
// Shared defaults and FSM state encoding for accel_driver.
package accel_driver_pkg;

  localparam int unsigned ACC_N      = 8;
  localparam int unsigned ACC_BITS   = 8;
  localparam logic [9:0]  ACC_A_BASE = 10'd128;
  localparam logic [9:0]  ACC_B_BASE = 10'd192;
  localparam logic [9:0]  ACC_C_BASE = 10'd256;
  localparam int unsigned ACC_SETTLE = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READ   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/accel_driver.sv
// Streams matrices A and B from source memory into the accelerator, waits, then reads C back.
// Build option: ACCEL_DRV_SIGN_EXT_EN selects sign- instead of zero-extension of written elements.
module accel_driver
  import accel_driver_pkg::*;
#(
  parameter int unsigned N      = ACC_N,
  parameter int unsigned BITS   = ACC_BITS,
  parameter logic [9:0]  A_BASE = ACC_A_BASE,
  parameter logic [9:0]  B_BASE = ACC_B_BASE,
  parameter logic [9:0]  C_BASE = ACC_C_BASE,
  parameter int unsigned SETTLE = ACC_SETTLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [6:0]      src_addr,
  input  logic [BITS-1:0] src_data,
  output logic [9:0]      bus_addr,
  output logic            bus_wr_en,
  output logic            bus_sel,
  output logic [31:0]     bus_wdata,
  input  logic [31:0]     bus_rdata,
  output logic            res_valid,
  output logic [5:0]      res_idx,
  output logic [31:0]     res_data
);

  localparam int unsigned NN = N * N;
  localparam int unsigned CW = $clog2(2 * NN + 1);

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] LOAD_LAST   = CW'(2 * NN);
  localparam logic [CW-1:0] LOAD_HALF   = CW'(NN);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] READ_LAST   = CW'(NN - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_res_valid;
  logic [5:0]      r_res_idx;
  logic [31:0]     r_res_data;

  logic [CW-1:0]   w_km1;
  logic [31:0]     w_ext;

`ifdef ACCEL_DRV_SIGN_EXT_EN
  assign w_ext = {{(32-BITS){src_data[BITS-1]}}, src_data};
`else
  assign w_ext = {{(32-BITS){1'b0}}, src_data};
`endif

  // src_data lags src_addr by one cycle, so LOAD count k writes element k-1.
  assign w_km1 = r_cnt - CNT_ONE;

  always_comb begin
    bus_sel   = 1'b0;
    bus_wr_en = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    src_addr  = '0;
    unique case (r_state)
      ST_LOAD: begin
        if (r_cnt < LOAD_LAST) src_addr = 7'(r_cnt);
        if (r_cnt != '0) begin
          bus_sel   = 1'b1;
          bus_wr_en = 1'b1;
          bus_wdata = w_ext;
          if (w_km1 < LOAD_HALF) bus_addr = A_BASE + 10'(w_km1);
          else                   bus_addr = B_BASE + 10'(w_km1 - LOAD_HALF);
        end
      end
      ST_READ: begin
        bus_sel  = 1'b1;
        bus_addr = C_BASE + 10'(r_cnt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= 1'b0;
      if (r_state != ST_IDLE && abort) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_LOAD;
              r_cnt   <= '0;
            end
          end
          ST_LOAD: begin
            if (r_cnt == LOAD_LAST) begin
              r_state <= ST_SETTLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
              r_state <= ST_READ;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_READ: begin
            r_res_valid <= 1'b1;
            r_res_idx   <= 6'(r_cnt);
            r_res_data  <= bus_rdata;
            if (r_cnt == READ_LAST) begin
              r_state <= ST_DONE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign res_valid = r_res_valid;
  assign res_idx   = r_res_idx;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_accel_driver.sv
// Self-checking bench for accel_driver: probe table plus randomized runs against a matrix-level model.
module tb_accel_driver;

  localparam int N       = 8;
  localparam int NN      = N * N;
  localparam int BITS    = 8;
  localparam int A_BASE  = 128;
  localparam int B_BASE  = 192;
  localparam int C_BASE  = 256;
  localparam int SETTLE  = 2;
  localparam int S0      = 2 * NN + 2;          // first SETTLE cycle after start
  localparam int R0      = S0 + SETTLE;         // first READ cycle
  localparam int EXP_DONE = R0 + NN;            // 196 at defaults

  logic        clk, rst, start, abort;
  logic        busy, done, bus_wr_en, bus_sel, res_valid;
  logic [6:0]  src_addr;
  logic [7:0]  src_data;
  logic [9:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata, res_data;
  logic [5:0]  res_idx;

  accel_driver #(
    .N(N), .BITS(BITS), .A_BASE(10'd128), .B_BASE(10'd192), .C_BASE(10'd256), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .src_addr(src_addr), .src_data(src_data),
    .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source memory: registered read, one cycle latency.
  logic [7:0] mem [0:127];
  always @(posedge clk) src_data <= mem[src_addr];

  // Accelerator peer: stores written words, answers C reads combinationally with A*B.
  logic [31:0] acc [0:1023];
  always @(posedge clk) if (bus_sel && bus_wr_en) acc[bus_addr] <= bus_wdata;

  always_comb begin
    logic [31:0] s;
    int r, c, idx;
    s = '0; r = 0; c = 0; idx = 0;
    bus_rdata = '0;
    if (bus_sel && !bus_wr_en && int'(bus_addr) >= C_BASE && int'(bus_addr) < C_BASE + NN) begin
      idx = int'(bus_addr) - C_BASE;
      r = idx / N;
      c = idx % N;
      for (int k = 0; k < N; k++) s = s + acc[A_BASE + r * N + k] * acc[B_BASE + k * N + c];
      bus_rdata = s;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ext8(input logic [7:0] b);
`ifdef ACCEL_DRV_SIGN_EXT_EN
    return {{24{b[7]}}, b};
`else
    return {24'h0, b};
`endif
  endfunction

  function automatic logic [31:0] c_model(input int i);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < N; k++)
      s = s + ext8(mem[(i / N) * N + k]) * ext8(mem[NN + k * N + (i % N)]);
    return s;
  endfunction

  function automatic logic [31:0] waddr_model(input int i);
    return (i < NN) ? 32'(A_BASE + i) : 32'(B_BASE + i - NN);
  endfunction

  // ---------------- monitor / bookkeeping ----------------
  typedef struct { logic [9:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [5:0] i; logic [31:0] d; } rs_t;
  wr_t wq[$];
  rs_t rq[$];
  int  rel, done_n, done_rel, sel_n;
  int  checks, errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rel++;
    if (bus_sel) sel_n++;
    if (bus_sel && bus_wr_en) wq.push_back('{bus_addr, bus_wdata});
    if (res_valid) rq.push_back('{res_idx, res_data});
    if (done) begin
      done_n++;
      done_rel = rel;
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    rq.delete();
    rel = 0; done_n = 0; done_rel = -1; sel_n = 0;
  endtask

  task automatic launch();
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run();
    while (rel < EXP_DONE + 3) tick();
  endtask

  task automatic check_run(input string nm);
    chk({nm, " write count"}, 32'(wq.size()), 32'(2 * NN));
    for (int i = 0; i < wq.size() && i < 2 * NN; i++) begin
      chk($sformatf("%s waddr[%0d]", nm, i), 32'(wq[i].a), waddr_model(i));
      chk($sformatf("%s wdata[%0d]", nm, i), wq[i].d, ext8(mem[i]));
    end
    chk({nm, " result count"}, 32'(rq.size()), 32'(NN));
    for (int i = 0; i < rq.size() && i < NN; i++) begin
      chk($sformatf("%s res_idx[%0d]", nm, i), 32'(rq[i].i), 32'(i));
      chk($sformatf("%s res_data[%0d]", nm, i), rq[i].d, c_model(i));
    end
    chk({nm, " done count"}, 32'(done_n), 32'd1);
    chk({nm, " done cycle"}, 32'(done_rel), 32'(EXP_DONE));
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 2 * NN; i++) mem[i] = 8'($urandom);
  endtask

  // ---------------- probe table ----------------
  typedef struct {
    int         t;
    logic       busy, done, sel, wr, rv;
    logic [9:0] addr;
    logic [6:0] saddr;
  } probe_t;
  probe_t tbl [$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2 * NN; i++) mem[i] = '0;

    //      t        busy  done  sel   wr    rv    addr          saddr
    tbl.push_back('{1,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   7'd0});
    tbl.push_back('{2,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd128, 7'd1});
    tbl.push_back('{65,       1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd191, 7'd64});
    tbl.push_back('{66,       1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd192, 7'd65});
    tbl.push_back('{129,      1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd255, 7'd0});
    tbl.push_back('{S0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   7'd0});
    tbl.push_back('{S0 + 1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   7'd0});
    tbl.push_back('{R0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd256, 7'd0});
    tbl.push_back('{R0 + 1,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd257, 7'd0});
    tbl.push_back('{R0 + 63,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd319, 7'd0});
    tbl.push_back('{EXP_DONE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0,   7'd0});
    tbl.push_back('{EXP_DONE + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 7'd0});

    // Reset state
    tick(); tick();
    chk("rst busy",      32'(busy), 32'd0);
    chk("rst done",      32'(done), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst res_idx",   32'(res_idx), 32'd0);
    chk("rst res_data",  res_data, 32'd0);
    chk("rst bus",       32'({bus_sel, bus_wr_en, bus_addr}), 32'd0);
    chk("rst wdata",     bus_wdata, 32'd0);
    chk("rst src_addr",  32'(src_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Run 1: A = identity, B[i] = i, so C[i] = i; probes at fixed cycles
    for (int i = 0; i < NN; i++) begin
      mem[i]      = (i / N == i % N) ? 8'd1 : 8'd0;
      mem[NN + i] = 8'(i);
    end
    launch();
    for (int e = 0; e < tbl.size(); e++) begin
      while (rel < tbl[e].t) tick();
      chk($sformatf("probe t=%0d", tbl[e].t),
          32'({busy, done, bus_sel, bus_wr_en, res_valid, bus_addr, src_addr}),
          32'({tbl[e].busy, tbl[e].done, tbl[e].sel, tbl[e].wr, tbl[e].rv, tbl[e].addr, tbl[e].saddr}));
    end
    finish_run();
    check_run("identity");
    for (int i = 0; i < rq.size(); i++) chk($sformatf("identity C[%0d]", i), rq[i].d, 32'(i));

    // Run 2: random data, 0xFF at index 5, extra start during LOAD k=50
    randomize_mem();
    mem[5] = 8'hFF;
    launch();
    while (rel < 51) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run();
    check_run("restart");
    if (wq.size() > 5) begin
      chk("ff addr", 32'(wq[5].a), 32'd133);
`ifdef ACCEL_DRV_SIGN_EXT_EN
      chk("ff data", wq[5].d, 32'hFFFF_FFFF);
`else
      chk("ff data", wq[5].d, 32'h0000_00FF);
`endif
    end else begin
      chk("ff write present", 32'(wq.size()), 32'd6);
    end

    // Run 3: abort during SETTLE
    randomize_mem();
    launch();
    while (rel < S0) tick();
    chk("settle busy/sel", 32'({busy, bus_sel}), 32'b10);
    chk("abort run writes", 32'(wq.size()), 32'(2 * NN));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("after abort busy/sel", 32'({busy, bus_sel}), 32'b00);
    begin
      int sel_at_abort;
      sel_at_abort = sel_n;
      for (int i = 0; i < 100; i++) tick();
      chk("abort no reads", 32'(sel_n - sel_at_abort), 32'd0);
    end
    chk("abort no results", 32'(rq.size()), 32'd0);
    chk("abort no done", 32'(done_n), 32'd0);

    // abort alone in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("idle abort busy", 32'(busy), 32'd0);

    // Run 4: start and abort together in IDLE -> start wins, full pass
    randomize_mem();
    clear_mon();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start wins busy", 32'(busy), 32'd1);
    finish_run();
    check_run("after_abort");

    // Run 5: reset in READ at j=10
    randomize_mem();
    launch();
    while (rel < R0 + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midread rst busy/sel/rv", 32'({busy, bus_sel, res_valid}), 32'd0);
    chk("midread rst res", 32'({res_idx, res_data}), 32'd0);
    chk("midread results", 32'(rq.size()), 32'd10);
    for (int i = 0; i < 5; i++) tick();
    chk("midread stays idle", 32'({busy, done_n[0]}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
